// File: rtl/ads_serial_rx_pkg.sv
// Shared types and helpers for the ADS167x-class serial receive engine.
// The FSM state set and the channel-index width rule live here.
package ads_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    FS,
    SHIFT
  } rx_state_t;

  // A single-device chain still needs a 1-bit channel tag.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ads_serial_rx_if.sv
// Received-word stream: one word per beat, tagged with its daisy-chain channel.
interface ads_serial_rx_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = 1
);

  logic [DATA_WIDTH-1:0] m_data;
  logic [CH_W-1:0]       m_chan;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_chan,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_chan,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/ads_serial_rx_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous active-low strobe, followed by
// an edge register that yields a one-cycle pulse on each falling edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the deasserted level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ads_serial_rx.sv
// Receive engine for daisy-chained delta-sigma ADCs: START pulse, DRDY wait,
// FS/SCLK generation, MSB-first shift-in and a channel-tagged output stream.
module ads_serial_rx
  import ads_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CH       = 1,
  parameter int CLK_DIV      = 4,
  parameter int START_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  output logic            start_o,
  input  logic            drdy_n_i,
  output logic            fs_o,
  output logic            sclk_o,
  input  logic            din_i,
  ads_serial_rx_if.master m_if,
  output logic            overrun_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int ST_W  = $clog2(START_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_CYCLES - 1);

  rx_state_t             state_q;
  logic [PH_W-1:0]       phase_q;
  logic [BIT_W-1:0]      bit_q;
  logic [CH_W-1:0]       chan_q;
  logic [ST_W-1:0]       st_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  start_q;
  logic                  fs_q;
  logic                  sclk_q;
  logic                  busy_q;
  logic                  frame_err_q;
  logic                  word_done_q;
  logic [CH_W-1:0]       word_chan_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_W-1:0]       chan_out_q;
  logic                  valid_q;
  logic                  overrun_q;

  logic                  drdy_fall;
  logic                  in_frame;

  sync_edge_det u_drdy_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (drdy_n_i),
    .fall_o  (drdy_fall)
  );

  assign shift_d  = {shift_q[DATA_WIDTH-2:0], din_i};
  assign in_frame = (state_q == FS) || (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      chan_q      <= '0;
      st_cnt_q    <= '0;
      shift_q     <= '0;
      start_q     <= 1'b0;
      fs_q        <= 1'b0;
      sclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      word_done_q <= 1'b0;
      word_chan_q <= '0;
    end else begin
      word_done_q <= 1'b0;
      // A DRDY edge inside a frame is flagged and swallowed; WAIT never sees it.
      frame_err_q <= drdy_fall && in_frame;

      if (!enable_i && (state_q != IDLE)) begin
        state_q  <= IDLE;
        start_q  <= 1'b0;
        fs_q     <= 1'b0;
        sclk_q   <= 1'b0;
        busy_q   <= 1'b0;
        phase_q  <= '0;
        bit_q    <= '0;
        chan_q   <= '0;
        st_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable_i) begin
              state_q  <= START;
              start_q  <= 1'b1;
              busy_q   <= 1'b1;
              st_cnt_q <= '0;
            end
          end

          START: begin
            if (st_cnt_q == ST_LAST) begin
              start_q <= 1'b0;
              state_q <= WAIT;
            end else begin
              st_cnt_q <= st_cnt_q + ST_W'(1);
            end
          end

          WAIT: begin
            if (drdy_fall) begin
              state_q <= FS;
              fs_q    <= 1'b1;
              phase_q <= '0;
              bit_q   <= '0;
              chan_q  <= '0;
            end
          end

          FS: begin
            if (phase_q == PH_LAST) begin
              state_q <= SHIFT;
              fs_q    <= 1'b0;
              sclk_q  <= 1'b1;
              phase_q <= '0;
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
          end

          SHIFT: begin
            // End of the high phase: the ADC launched din on the rise, sample now.
            if (phase_q == PH_MID) begin
              sclk_q  <= 1'b0;
              shift_q <= shift_d;
              if (bit_q == BIT_LAST) begin
                bit_q       <= '0;
                word_done_q <= 1'b1;
                word_chan_q <= chan_q;
                chan_q      <= (chan_q == CH_LAST) ? '0 : chan_q + CH_W'(1);
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end

            // bit and channel counters both back at zero at the end of a low
            // phase only once the last word of the chain has been taken.
            if (phase_q == PH_LAST) begin
              phase_q <= '0;
              if ((bit_q == '0) && (chan_q == '0)) begin
                state_q <= WAIT;
              end else begin
                sclk_q <= 1'b1;
              end
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
          end

          default: begin
            state_q <= IDLE;
            start_q <= 1'b0;
            fs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Single-entry output holding register; a full register drops the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      chan_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (word_done_q) begin
        if (valid_q && !m_if.m_ready) begin
          overrun_q <= 1'b1;
        end else begin
          data_q     <= shift_q;
          chan_out_q <= word_chan_q;
          valid_q    <= 1'b1;
        end
      end else if (valid_q && m_if.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign start_o     = start_q;
  assign fs_o        = fs_q;
  assign sclk_o      = sclk_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  assign m_if.m_data  = data_q;
  assign m_if.m_chan  = chan_out_q;
  assign m_if.m_valid = valid_q;

endmodule

// File: doc/ads_serial_rx.md
# ads_serial_rx

Parametrised receive engine for daisy-chained ADS167x-class delta-sigma ADCs with a frame-sync serial port. Generates the START pulse, waits for a synchronised DRDY falling edge, drives FS and SCLK, shifts in NUM_CH words of DATA_WIDTH bits MSB-first, and presents each word on a valid/ready stream tagged with its channel index. It sits between the ADC header pins and the sample-processing fabric, and replaces the fixed single-channel 24-bit EVM sequencer.

## Interface
- DATA_WIDTH, 24, bits per channel word (8..32)
- NUM_CH, 1, words per frame, one per daisy-chained device (1..8)
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
- START_CYCLES, 4, width of START pulse in clk cycles (>=1)
- CH_W, $clog2(NUM_CH) min 1, width of m_chan (derived localparam)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- start  out  1  ADC START pin
- drdy_n  in  1  ADC data-ready, asynchronous, active-low
- fs  out  1  frame sync to ADC
- sclk  out  1  serial clock to ADC, idles low
- din  in  1  serial data from ADC
- m_data  out  DATA_WIDTH  received word, raw two's complement
- m_chan  out  CH_W  channel index of m_data (0 = first word shifted)
- m_valid  out  1  m_data/m_chan valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- overrun  out  1  one-cycle pulse: word dropped, output register full
- frame_err  out  1  one-cycle pulse: DRDY fell during shift
- busy  out  1  high in any state other than IDLE

## Operation
- Reset: all outputs 0, sclk 0, state IDLE, shift/bit/channel counters 0.
- IDLE: if enable is high, go to START.
- START: start=1 for START_CYCLES cycles, then go to WAIT.
- WAIT: on a synchronised drdy_n falling edge, go to FS.
- FS: fs=1 and sclk=0 for 2*CLK_DIV cycles, then go to SHIFT.
- SHIFT: sclk high for CLK_DIV cycles, then low for CLK_DIV cycles, per bit.
  - din is sampled on the clk cycle in which sclk goes high to low.
  - Samples shift in MSB-first. After DATA_WIDTH samples the word is complete and the channel counter increments.
  - After NUM_CH words, go to WAIT. START is not re-pulsed.
- Output register: a completed word loads m_data/m_chan and sets m_valid the next cycle. m_valid clears on handshake.
  - If a word completes while m_valid && !m_ready, the new word is dropped, overrun pulses, and the held word is unchanged.
  - If a word completes in the same cycle as a handshake, the new word loads and no overrun is raised.
- drdy_n falling edge detected in FS or SHIFT: frame_err pulses and the current frame continues. That edge is consumed and does not start a new frame.
- enable low in START/WAIT/FS/SHIFT: abort next cycle to IDLE. start, fs and sclk go to 0, and the partial word is discarded. A word already held in the output register stays until accepted.
- enable high again after an abort: the full START sequence reruns.

## Timing
- drdy_n goes through a 2-flop synchroniser plus an edge register. fs rises 3 clk cycles after drdy_n falls (in WAIT).
- First sclk rise: 2*CLK_DIV cycles after fs rises. fs falls in the same cycle sclk first rises.
- Frame length: 2*CLK_DIV*(1 + DATA_WIDTH*NUM_CH) cycles from fs rise to return to WAIT.
- Latency: m_valid rises 1 cycle after the falling-edge tick of the word's last bit.
- The ADC launches din on sclk rise. Sampling at the end of the high phase gives CLK_DIV clk cycles of setup.
- CLK_DIV=1 is legal: sclk = clk/2.

## Structure
- Package ads_rx_pkg holds:
  - the state enum rx_state_t (IDLE, START, WAIT, FS, SHIFT);
  - a helper function for the CH_W minimum-1 rule.
- Sub-module sync_edge_det: 2-flop synchroniser plus falling-edge pulse, reset value 1 (deasserted level). Instantiated for drdy_n.
- Counters:
  - phase counter, $clog2(2*CLK_DIV) bits;
  - bit counter, $clog2(DATA_WIDTH) bits;
  - channel counter, CH_W bits;
  - START counter, $clog2(START_CYCLES+1) bits.

## Test plan
- Single channel, DATA_WIDTH=24, CLK_DIV=4: ADC model drives 0xA5C3F1 -> one m_valid with m_data=0xA5C3F1, m_chan=0; fs 3 cycles after drdy_n falls; 200 clk frame.
- NUM_CH=4, DATA_WIDTH=16, words 0x0001/0x8000/0x7FFF/0xFFFF, m_ready tied high -> four beats with m_chan 0..3, in order, no overrun.
- m_ready held low across a 2-channel frame -> first word held, overrun pulses exactly once, m_data unchanged; m_ready high then accepts the first word.
- drdy_n pulsed low mid-SHIFT -> frame_err single pulse, frame completes with correct data, block returns to WAIT awaiting the next edge.
- enable dropped mid-word, then raised -> sclk/fs low within 1 cycle, state IDLE, no partial word emitted; START pulses START_CYCLES cycles and the next frame is correct.
- rst asserted mid-SHIFT with m_valid high -> all outputs 0 immediately (asynchronous); after release the block starts in IDLE.
